// File: rtl/bmu_seq_unit.sv
// bmu_seq_unit: iterative CLMUL/CLMULH/CLMULR/CLZ/CPOP/CTZ, STEP bits per cycle; ports clk, rst(async), start/option/rs1/rs2 in, busy/done/result out
module bmu_seq_unit #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  option,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int N = 32 / STEP;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [4:0] op;
  logic [63:0] m, acc, acc_n;
  logic [31:0] sb, res_n;
  logic [5:0] cnt, cnt_n;
  logic fnd, fnd_n, bt, is_clm, accept, last;
  logic [CW-1:0] k;
  assign is_clm = op == 5'd1 || op == 5'd2 || op == 5'd3;
  assign accept = start && state != RUN;
  assign last = k == CW'(N - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    acc_n = acc;
    cnt_n = cnt;
    fnd_n = fnd;
    bt = 1'b0;
    for (int j = 0; j < STEP; j++) begin
      bt = op == 5'd4 ? m[31-j] : sb[j];
      acc_n = (is_clm && sb[j]) ? acc_n ^ (m << j) : acc_n;
      cnt_n = cnt_n + 6'(op == 5'd5 ? sb[j] : (op == 5'd4 || op == 5'd6) && !fnd_n && !bt);
      fnd_n = fnd_n | bt;
    end
    res_n = op == 5'd1 ? acc_n[31:0] :
            op == 5'd2 ? acc_n[63:32] :
            op == 5'd3 ? acc_n[62:31] :
            (op == 5'd4 || op == 5'd5 || op == 5'd6) ? {26'd0, cnt_n} : 32'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      m <= '0;
      sb <= '0;
      acc <= '0;
      cnt <= '0;
      fnd <= 1'b0;
      k <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= option;
        m <= {32'd0, rs1};
        sb <= (option == 5'd1 || option == 5'd2 || option == 5'd3) ? rs2 : rs1;
        acc <= '0;
        cnt <= '0;
        fnd <= 1'b0;
        k <= '0;
      end else if (state == RUN) begin
        acc <= acc_n;
        cnt <= cnt_n;
        fnd <= fnd_n;
        m <= m << STEP;
        sb <= sb >> STEP;
        k <= k + 1'b1;
        if (last) result <= res_n;
      end
    end
  end
endmodule

// File: tb/tb_bmu_seq_unit.sv
// tb_bmu_seq_unit: scoreboard bench for bmu_seq_unit at STEP=1 and STEP=4
module tb_bmu_seq_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] st = 2'b00;
  logic [1:0] bsy, dn;
  logic [4:0] opt [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [31:0] res [2];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bcnt [2];
  logic [31:0] prev [2];
  typedef struct {logic [31:0] r; int c;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  typedef struct {logic [4:0] o; logic [31:0] x; logic [31:0] y; logic [31:0] r;} vec_t;
  vec_t tbl [10] = '{
    '{5'd1, 32'h00000003, 32'h00000003, 32'h00000005},
    '{5'd1, 32'h80000000, 32'h80000000, 32'h00000000},
    '{5'd2, 32'h80000000, 32'h80000000, 32'h40000000},
    '{5'd3, 32'h80000000, 32'h80000000, 32'h80000000},
    '{5'd4, 32'h00010000, 32'h0, 32'd15},
    '{5'd4, 32'h00000000, 32'h0, 32'd32},
    '{5'd6, 32'h00010000, 32'h0, 32'd16},
    '{5'd6, 32'h00000000, 32'h0, 32'd32},
    '{5'd5, 32'hF0F0F0F0, 32'h0, 32'd16},
    '{5'd5, 32'hFFFFFFFF, 32'h0, 32'd32}
  };
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bmu_seq_unit #(.STEP(1)) u1 (.clk(clk), .rst(rst), .start(st[0]), .option(opt[0]), .rs1(a[0]), .rs2(b[0]),
                              .busy(bsy[0]), .done(dn[0]), .result(res[0]));
  bmu_seq_unit #(.STEP(4)) u4 (.clk(clk), .rst(rst), .start(st[1]), .option(opt[1]), .rs1(a[1]), .rs2(b[1]),
                              .busy(bsy[1]), .done(dn[1]), .result(res[1]));
  function automatic int nn(input int d);
    return d == 0 ? 32 : 8;
  endfunction
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p = '0;
    int n = 0;
    if (o >= 5'd1 && o <= 5'd3) begin
      for (int i = 0; i < 32; i++) if (y[i]) p = p ^ ({32'd0, x} << i);
      return o == 5'd1 ? p[31:0] : o == 5'd2 ? p[63:32] : p[62:31];
    end
    if (o == 5'd5) for (int i = 0; i < 32; i++) n += int'(x[i]);
    if (o == 5'd4) while (n < 32 && !x[31-n]) n++;
    if (o == 5'd6) while (n < 32 && !x[n]) n++;
    return (o >= 5'd4 && o <= 5'd6) ? 32'(n) : 32'd0;
  endfunction
  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h at cycle %0d", nm, d, act, exp, cyc);
    end
  endtask
  task automatic mon(input int d);
    exp_t e;
    int qs;
    if (rst) begin
      bcnt[d] = 0;
      prev[d] = res[d];
      return;
    end
    if (bsy[d]) bcnt[d]++;
    if (dn[d]) begin
      qs = d == 0 ? q0.size() : q1.size();
      chk("done_expected", d, 32'(qs > 0), 32'd1);
      if (qs > 0) begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk("result", d, res[d], e.r);
        chk("latency", d, 32'(cyc - e.c), 32'(nn(d)));
        chk("busy_cycles", d, 32'(bcnt[d]), 32'(nn(d)));
      end
      bcnt[d] = 0;
    end else chk("result_hold", d, res[d], prev[d]);
    prev[d] = res[d];
  endtask
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end
  task automatic issue(input int d, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input bit p);
    exp_t e;
    st[d] = 1'b1;
    opt[d] = o;
    a[d] = x;
    b[d] = y;
    @(posedge clk);
    #1;
    e.r = r;
    e.c = cyc;
    if (p && d == 0) q0.push_back(e);
    if (p && d == 1) q1.push_back(e);
    st[d] = 1'b0;
    opt[d] = 5'($urandom);
    a[d] = $urandom;
    b[d] = $urandom;
  endtask
  task automatic wait_done(input int d, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dn[d]) begin
        t = cyc;
        return;
      end
    end
    chk("done_seen", d, 32'(dn[d]), 32'd1);
  endtask
  initial begin
    int t1, t2;
    logic [4:0] o;
    logic [31:0] x, y;
    for (int d = 0; d < 2; d++) begin
      opt[d] = '0;
      a[d] = '0;
      b[d] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", d, 32'(bsy[d]), 0);
      chk("reset_done", d, 32'(dn[d]), 0);
      chk("reset_result", d, res[d], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      foreach (tbl[i]) begin
        issue(d, tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].r, 1'b1);
        wait_done(d, t1);
        @(negedge clk);
      end
      issue(d, 5'd5, 32'hFFFFFFFF, 32'h0, 32'd32, 1'b1);
      repeat (3) @(negedge clk);
      issue(d, 5'd4, 32'h12345678, 32'h0, 32'd0, 1'b0);
      wait_done(d, t1);
      repeat (40) @(negedge clk);
      issue(d, 5'd6, 32'h00000008, 32'h0, 32'd3, 1'b1);
      wait_done(d, t1);
      issue(d, 5'd5, 32'h00000007, 32'h0, 32'd3, 1'b1);
      wait_done(d, t2);
      chk("b2b_gap", d, 32'(t2 - t1), 32'(nn(d) + 1));
      @(negedge clk);
      for (int i = 0; i < 25; i++) begin
        o = $urandom_range(0, 9) < 6 ? 5'($urandom_range(1, 6)) : 5'($urandom_range(0, 31));
        x = ($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 31);
        y = $urandom >> $urandom_range(0, 31);
        issue(d, o, x, y, model(o, x, y), 1'b1);
        wait_done(d, t1);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);
    end
    issue(0, 5'd1, 32'hDEADBEEF, 32'h12345679, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    chk("busy_before_rst", 0, 32'(bsy[0]), 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 0, 32'(bsy[0]), 0);
    chk("rst_done", 0, 32'(dn[0]), 0);
    chk("rst_result", 0, res[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(0, 5'd4, 32'h00000001, 32'h0, 32'd31, 1'b1);
    wait_done(0, t1);
    repeat (40) @(negedge clk);
    chk("q0_empty", 0, 32'(q0.size()), 0);
    chk("q1_empty", 1, 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
